logic_accum: RTL and testbench
==============================

# logic_accum

Parametrised streaming bitwise logic accumulator, the successor to the two-input AND gate. It folds a packet of WIDTH-bit operands, one per accepted beat, with a selectable operation (AND/OR/XOR/NAND), and counts the beats. It emits one registered result per packet through a valid/ready output. It sits between a producer stream and any consumer that needs a multi-operand bitwise reduction.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- CNT_W, 8, beat counter width in bits (≥2)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND (AND-fold, result inverted)
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  WIDTH  operand
- in_last  input  1  marks the final beat of a packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result when out_valid && out_ready
- out_data  output  WIDTH  folded result
- out_count  output  CNT_W  beats in the packet, saturating
- out_overflow  output  1  packet beat count exceeded 2^CNT_W-1

## Operation
- States: IDLE (no packet open) and ACCUM (packet open). The output register is independent of the FSM.
- First beat accepted in IDLE:
  - acc ← in_data; cnt ← 1; ovf ← 0.
  - Latch op into op_q; op_q is held for the whole packet, so op changes mid-packet are ignored.
  - If in_last=0, go to ACCUM.
- Beat accepted in ACCUM:
  - acc ← acc OP in_data, where OP is AND for op_q 00/11, OR for 01, XOR for 10.
  - cnt ← cnt+1, saturating at 2^CNT_W-1. ovf ← 1 when an increment is attempted at saturation.
- Beat accepted with in_last=1 in either state:
  - Load the output register: out_data ← final acc (inverted if op_q=11), out_count ← final cnt, out_overflow ← final ovf. The final values include this beat.
  - Set out_valid=1 and go to IDLE.
- Single-beat packet: out_data = in_data (or ~in_data for NAND), out_count = 1.
- in_ready = !out_valid || out_ready, applied to every beat. This keeps the design simple and gives a combinational path out_ready→in_ready.
- out_valid clears on a handshake, unless a new last beat is accepted in the same cycle. In that case out_valid stays 1 and the output register takes the new result.
- Output fields stay stable while out_valid && !out_ready.
- in_data and in_last are ignored when in_valid=0.

## Timing
- Reset values (async assert, sync to clk on deassert): state IDLE, acc 0, cnt 0, ovf 0, op_q 0, out_valid 0, out_data 0, out_count 0, out_overflow 0. in_ready is therefore 1.
- Latency: the result is visible with out_valid=1 one cycle after the edge that accepts the last beat.
- Throughput: one beat per cycle. Back-to-back single-beat packets run at one result per cycle when out_ready=1.
- Backpressure: if out_valid=1 and out_ready=0, in_ready=0. No beat is accepted, and acc and cnt hold.
- Reset mid-packet: the partial packet is discarded. A pending result is dropped.
- Counter overflow: out_count sticks at 2^CNT_W-1 with out_overflow=1; the fold is unaffected.

## Test plan
- Truth table: WIDTH=1, op=00, four 2-beat packets (0,0), (0,1), (1,0), (1,1), out_ready=1. Expect out_data 0,0,0,1, each with out_count=2.
- Mode sweep: WIDTH=8, packet 0xF0, 0x3C, 0x0F. Expect:
  - op=00 → 0x00
  - op=01 → 0xFF
  - op=10 → 0xC3
  - op=11 → 0xFF
  - Change op mid-packet: the result is unchanged.
- Backpressure: hold out_ready=0 after result 0xAA is produced, while driving in_valid=1. Expect:
  - in_ready=0, with out_data=0xAA stable for 5 cycles.
  - Raise out_ready: the next beat is accepted the same cycle.
- Simultaneous drain and load: single-beat packets 0x11, 0x22, 0x33 back-to-back with out_ready=1. Expect out_valid held high and out_data 0x11, 0x22, 0x33 on consecutive cycles.
- Overflow: CNT_W=2, 5-beat XOR packet of 0x01. Expect out_count=3, out_overflow=1, out_data=0x01.
- Reset mid-packet: assert rst_n=0 after 2 beats. Expect all outputs 0 and in_ready=1. A new 1-beat packet 0x5A then gives out_data 0x5A, out_count 1.

Source files
------------

// File: rtl/logic_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_accum_if
// Purpose  : Bundles the operand stream (op, in_valid/in_ready, in_data,
//            in_last) and the result stream (out_valid/out_ready, out_data,
//            out_count, out_overflow) of logic_accum.
// Modports : master - producer/consumer side (drives operands and out_ready)
//            slave  - accumulator side (drives in_ready and the result)
// Revision : 1.0 - initial release
// ============================================================================
interface logic_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_overflow
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/logic_accum.sv
`default_nettype none
// ============================================================================
// Module   : logic_accum
// Purpose  : Streaming bitwise accumulator. Folds each packet of WIDTH-bit
//            operands with AND / OR / XOR / NAND (op latched on the first
//            beat), counts beats with a saturating counter and presents one
//            registered result per packet on a valid/ready output.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - logic_accum_if.slave (operand and result streams)
// Revision : 1.0 - initial release
// ============================================================================
module logic_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    logic_accum_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [1:0]       C_OP_OR   = 2'b01;
    localparam logic [1:0]       C_OP_XOR  = 2'b10;
    localparam logic [1:0]       C_OP_NAND = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [1:0]       r_op_q;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_overflow;

    logic             w_in_ready;
    logic             w_accept;
    logic [1:0]       w_op_eff;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic [WIDTH-1:0] w_result;

    // A beat may enter whenever the output slot is free or being drained
    // this cycle; this gives a combinational out_ready -> in_ready path.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Candidate accumulator values if the current beat is accepted. In IDLE
    // the beat opens a packet, so the live op is used; in ACCUM the op
    // captured at packet start governs the fold.
    always_comb begin
        w_state_next = r_state;
        w_op_eff     = r_op_q;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;

        if (r_state == S_IDLE) begin
            w_op_eff   = bus.op;
            w_acc_next = bus.in_data;
            w_cnt_next = C_CNT_ONE;
            w_ovf_next = 1'b0;
        end else begin
            case (r_op_q)
                C_OP_OR:  w_acc_next = r_acc | bus.in_data;
                C_OP_XOR: w_acc_next = r_acc ^ bus.in_data;
                default:  w_acc_next = r_acc & bus.in_data; // AND and NAND
            endcase
            // Saturate the count; remember that an increment was lost.
            w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);
            w_ovf_next = r_ovf || (r_cnt == C_CNT_MAX);
        end

        // NAND is an AND fold with the final value inverted.
        w_result = (w_op_eff == C_OP_NAND) ? ~w_acc_next : w_acc_next;

        if (w_accept) begin
            w_state_next = bus.in_last ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_op_q <= 2'b00;
        end else if (w_accept) begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_ovf  <= w_ovf_next;
            r_op_q <= w_op_eff;
        end
    end

    // Output slot: a last beat always (re)loads it, which covers the case of
    // draining the old result and loading a new one in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_accept && bus.in_last) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_result;
            r_out_count    <= w_cnt_next;
            r_out_overflow <= w_ovf_next;
        end else if (bus.out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_count    = r_out_count;
    assign bus.out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: tb/tb_logic_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_accum
// Purpose  : Self-checking bench for logic_accum. Three instances:
//            ua (WIDTH=8, CNT_W=8) checked every cycle against a packet-level
//            reference model, ub (WIDTH=1) for the AND truth table and
//            uc (WIDTH=8, CNT_W=2) for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_accum;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic_accum_if #(.WIDTH(8), .CNT_W(8)) ia ();
    logic_accum_if #(.WIDTH(1), .CNT_W(8)) ib ();
    logic_accum_if #(.WIDTH(8), .CNT_W(2)) ic ();

    logic_accum #(.WIDTH(8), .CNT_W(8)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
    logic_accum #(.WIDTH(1), .CNT_W(8)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));
    logic_accum #(.WIDTH(8), .CNT_W(2)) uc (.clk(clk), .rst_n(rst_n), .bus(ic));

    int tests = 0;
    int fails = 0;

    // Reference model state for ua: the result slot and the open packet.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_count;
    logic       m_ovf;
    logic [1:0] pkt_op;
    logic [7:0] pkt[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fold a whole packet from scratch.
    function automatic logic [7:0] fold_pkt(input logic [1:0] op_s, input logic [7:0] q[$]);
        logic [7:0] r;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (op_s == 2'b01)      r = r | q[i];
            else if (op_s == 2'b10) r = r ^ q[i];
            else                    r = r & q[i];
        end
        if (op_s == 2'b11) r = ~r;
        return r;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_count = 0;
        m_ovf   = 1'b0;
        pkt_op  = 2'b00;
        pkt.delete();
    endtask

    // One clock cycle on ua: drive, check against the model mid-cycle, then
    // advance the model across the coming edge.
    task automatic cycle_a(input logic v, input logic [7:0] d, input logic l,
                           input logic [1:0] o, input logic rdy);
        logic acc;
        int   n;
        ia.in_valid  = v;
        ia.in_data   = d;
        ia.in_last   = l;
        ia.op        = o;
        ia.out_ready = rdy;
        @(negedge clk);
        chk("a_in_ready", 32'(ia.in_ready), 32'(!m_valid || rdy));
        chk("a_out_valid", 32'(ia.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("a_out_data", 32'(ia.out_data), 32'(m_data));
            chk("a_out_count", 32'(ia.out_count), 32'(m_count));
            chk("a_out_overflow", 32'(ia.out_overflow), 32'(m_ovf));
        end
        acc = v && (!m_valid || rdy);
        if (m_valid && rdy) m_valid = 1'b0;
        if (acc) begin
            if (pkt.size() == 0) pkt_op = o;
            pkt.push_back(d);
            if (l) begin
                n       = pkt.size();
                m_valid = 1'b1;
                m_data  = fold_pkt(pkt_op, pkt);
                m_count = (n > 255) ? 255 : n;
                m_ovf   = (n > 255);
                pkt.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_sweep [4];
    logic       exp_tt [4];
    logic [7:0] drain_vals [3];

    initial begin
        exp_sweep  = '{8'h00, 8'hFF, 8'hC3, 8'hFF};
        exp_tt     = '{1'b0, 1'b0, 1'b0, 1'b1};
        drain_vals = '{8'h11, 8'h22, 8'h33};

        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_last = 1'b0; ia.op = 2'b00; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_last = 1'b0; ib.op = 2'b00; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.in_data = '0; ic.in_last = 1'b0; ic.op = 2'b00; ic.out_ready = 1'b1;
        model_clear();

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_out_data", 32'(ia.out_data), 32'd0);
        chk("rst_out_count", 32'(ia.out_count), 32'd0);
        chk("rst_out_overflow", 32'(ia.out_overflow), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(ib.out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // WIDTH=1 AND truth table, 2-beat packets
        for (int k = 0; k < 4; k++) begin
            ib.in_valid = 1'b1;
            ib.in_data  = k[1];
            ib.in_last  = 1'b0;
            tick();
            ib.in_data  = k[0];
            ib.in_last  = 1'b1;
            tick();
            ib.in_valid = 1'b0;
            chk("tt_valid", 32'(ib.out_valid), 32'd1);
            chk("tt_data", 32'(ib.out_data), 32'(exp_tt[k]));
            chk("tt_count", 32'(ib.out_count), 32'd2);
        end

        // CNT_W=2 saturation: 5-beat XOR packet of 0x01
        ic.op       = 2'b10;
        ic.in_valid = 1'b1;
        ic.in_data  = 8'h01;
        for (int k = 0; k < 5; k++) begin
            ic.in_last = (k == 4);
            tick();
        end
        ic.in_valid = 1'b0;
        chk("ovf_valid", 32'(ic.out_valid), 32'd1);
        chk("ovf_count", 32'(ic.out_count), 32'd3);
        chk("ovf_flag", 32'(ic.out_overflow), 32'd1);
        chk("ovf_data", 32'(ic.out_data), 32'h01);

        // Mode sweep over F0, 3C, 0F
        for (int o = 0; o < 4; o++) begin
            cycle_a(1'b1, 8'hF0, 1'b0, 2'(o), 1'b1);
            cycle_a(1'b1, 8'h3C, 1'b0, 2'(o), 1'b1);
            cycle_a(1'b1, 8'h0F, 1'b1, 2'(o), 1'b1);
            chk("sweep_data", 32'(ia.out_data), 32'(exp_sweep[o]));
            chk("sweep_count", 32'(ia.out_count), 32'd3);
        end
        // op changes mid-packet are ignored
        cycle_a(1'b1, 8'hF0, 1'b0, 2'b00, 1'b1);
        cycle_a(1'b1, 8'h3C, 1'b0, 2'b01, 1'b1);
        cycle_a(1'b1, 8'h0F, 1'b1, 2'b10, 1'b1);
        chk("midop_data", 32'(ia.out_data), 32'h00);
        cycle_a(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

        // Backpressure on result 0xAA
        cycle_a(1'b1, 8'hAA, 1'b1, 2'b01, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle_a(1'b1, 8'h77, 1'b1, 2'b00, 1'b0);
            chk("bp_in_ready", 32'(ia.in_ready), 32'd0);
            chk("bp_data", 32'(ia.out_data), 32'hAA);
        end
        cycle_a(1'b1, 8'h55, 1'b1, 2'b00, 1'b1);
        chk("bp_release_data", 32'(ia.out_data), 32'h55);

        // Simultaneous drain and load
        for (int k = 0; k < 3; k++) begin
            cycle_a(1'b1, drain_vals[k], 1'b1, 2'b00, 1'b1);
            chk("dl_valid", 32'(ia.out_valid), 32'd1);
            chk("dl_data", 32'(ia.out_data), 32'(drain_vals[k]));
        end
        cycle_a(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle_a(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 3),
                    2'($urandom), ($urandom_range(0, 9) < 7));
        end
        cycle_a(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
        cycle_a(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

        // Reset mid-packet
        cycle_a(1'b1, 8'h12, 1'b0, 2'b01, 1'b1);
        cycle_a(1'b1, 8'h34, 1'b0, 2'b01, 1'b1);
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        model_clear();
        chk("mrst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("mrst_out_data", 32'(ia.out_data), 32'd0);
        chk("mrst_out_count", 32'(ia.out_count), 32'd0);
        chk("mrst_out_overflow", 32'(ia.out_overflow), 32'd0);
        chk("mrst_in_ready", 32'(ia.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        cycle_a(1'b1, 8'h5A, 1'b1, 2'b00, 1'b0);
        chk("post_rst_data", 32'(ia.out_data), 32'h5A);
        chk("post_rst_count", 32'(ia.out_count), 32'd1);
        cycle_a(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
